// File: rtl/hdr_merge_n.sv
// hdr_merge_n: N-exposure HDR pixel merge, hat-weighted mean of NUM_EXP samples.
// Ports: clk, rst_n (async active-low), in_valid/in_ready + data_i/user_i (input beat),
//        out_valid/out_ready + data_o/user_o (merged pixel and its sideband).
// Macro HDR_MERGE_ROUND_EN: round half up on the quotient; otherwise truncate.
// Pipeline: weights, products, sums, PIX_WIDTH divider stages, output register.
module hdr_merge_n #(
  parameter int NUM_EXP    = 2,
  parameter int PIX_WIDTH  = 8,
  parameter int USER_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_EXP*PIX_WIDTH-1:0]  data_i,
  input  logic [USER_WIDTH-1:0]         user_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PIX_WIDTH-1:0]          data_o,
  output logic [USER_WIDTH-1:0]         user_o
);
  localparam int PW  = PIX_WIDTH;
  localparam int CL  = $clog2(NUM_EXP);
  localparam int WW  = PW - 1;
  localparam int DW  = WW + CL;
  localparam int PRW = 2 * PW - 1;
  localparam int EW  = PRW + CL;
  localparam logic [PW-1:0] M = '1;
  localparam logic [PW-1:0] H = M >> 1;
  logic                  ce;
  logic [WW-1:0]         w_d  [NUM_EXP];
  logic [WW-1:0]         w1_q [NUM_EXP];
  logic [PW-1:0]         z1_q [NUM_EXP];
  logic [USER_WIDTH-1:0] u1_q;
  logic                  v1_q;
  logic [PRW-1:0]        p_d  [NUM_EXP];
  logic [PRW-1:0]        p2_q [NUM_EXP];
  logic [PW-1:0]         z2_q [NUM_EXP];
  logic [DW-1:0]         d_d, d2_q;
  logic [USER_WIDTH-1:0] u2_q;
  logic                  v2_q;
  logic [EW-1:0]         e_d;
  logic [PW-1:0]         zm_d;
  // slot 0 is the sum stage; slots 1..PW each resolve one quotient bit, MSB first
  logic [EW-1:0]         r_q  [0:PW];
  logic [DW-1:0]         dd_q [0:PW];
  logic [PW-1:0]         q_q  [0:PW];
  logic                  zf_q [0:PW];
  logic [PW-1:0]         zm_q [0:PW];
  logic [USER_WIDTH-1:0] u_q  [0:PW];
  logic                  v_q  [0:PW];
  logic [EW-1:0]         sh   [1:PW];
  logic                  ge   [1:PW];
  logic                  rnd;
  logic [PW:0]           qr;
  logic [PW-1:0]         res;
  assign ce       = out_ready | ~out_valid;
  assign in_ready = ce;
  always_comb begin
    d_d  = '0;
    e_d  = '0;
    zm_d = '0;
    for (int k = 0; k < NUM_EXP; k++) begin
      w_d[k] = (data_i[k*PW +: PW] <= H) ? data_i[k*PW +: WW] : WW'(M - data_i[k*PW +: PW]);
      p_d[k] = PRW'(w1_q[k]) * PRW'(z1_q[k]);
      d_d    = d_d + DW'(w1_q[k]);
      e_d    = e_d + EW'(p2_q[k]);
      zm_d   = (z2_q[k] > zm_d) ? z2_q[k] : zm_d;
    end
  end
  always_comb begin
    for (int k = 1; k <= PW; k++) begin
      sh[k] = EW'(dd_q[k-1]) << (PW - k);
      ge[k] = r_q[k-1] >= sh[k];
    end
  end
`ifdef HDR_MERGE_ROUND_EN
  // final remainder is below D, so its low DW bits hold it exactly
  assign rnd = {r_q[PW][DW-1:0], 1'b0} >= {1'b0, dd_q[PW]};
`else
  assign rnd = 1'b0;
`endif
  assign qr  = {1'b0, q_q[PW]} + (PW+1)'(rnd);
  assign res = qr[PW] ? M : qr[PW-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      u1_q <= '0;
      v2_q <= 1'b0;
      u2_q <= '0;
      d2_q <= '0;
      for (int k = 0; k < NUM_EXP; k++) begin
        w1_q[k] <= '0;
        z1_q[k] <= '0;
        p2_q[k] <= '0;
        z2_q[k] <= '0;
      end
      for (int k = 0; k <= PW; k++) begin
        r_q[k]  <= '0;
        dd_q[k] <= '0;
        q_q[k]  <= '0;
        zf_q[k] <= 1'b0;
        zm_q[k] <= '0;
        u_q[k]  <= '0;
        v_q[k]  <= 1'b0;
      end
      out_valid <= 1'b0;
      data_o    <= '0;
      user_o    <= '0;
    end else if (ce) begin
      v1_q <= in_valid;
      u1_q <= user_i;
      v2_q <= v1_q;
      u2_q <= u1_q;
      d2_q <= d_d;
      for (int k = 0; k < NUM_EXP; k++) begin
        w1_q[k] <= w_d[k];
        z1_q[k] <= data_i[k*PW +: PW];
        p2_q[k] <= p_d[k];
        z2_q[k] <= z1_q[k];
      end
      r_q[0]  <= e_d;
      dd_q[0] <= d2_q;
      q_q[0]  <= '0;
      zf_q[0] <= (d2_q == '0);
      zm_q[0] <= zm_d;
      u_q[0]  <= u2_q;
      v_q[0]  <= v2_q;
      for (int k = 1; k <= PW; k++) begin
        r_q[k]  <= ge[k] ? r_q[k-1] - sh[k] : r_q[k-1];
        q_q[k]  <= q_q[k-1] | (PW'(ge[k]) << (PW - k));
        dd_q[k] <= dd_q[k-1];
        zf_q[k] <= zf_q[k-1];
        zm_q[k] <= zm_q[k-1];
        u_q[k]  <= u_q[k-1];
        v_q[k]  <= v_q[k-1];
      end
      out_valid <= v_q[PW];
      data_o    <= zf_q[PW] ? zm_q[PW] : res;
      user_o    <= u_q[PW];
    end
  end
endmodule

// File: tb/tb_hdr_merge_n.sv
// tb_hdr_merge_n: directed and scoreboard checks of hdr_merge_n (NUM_EXP=2 and 3, PIX_WIDTH=8).
module tb_hdr_merge_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] data_i = '0;
  logic [1:0]  user_i = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  data_o;
  logic [1:0]  user_o;
  logic        iv3 = 1'b0;
  logic        ir3;
  logic [23:0] d3 = '0;
  logic [1:0]  us3 = '0;
  logic        ov3;
  logic [7:0]  do3;
  logic [1:0]  uo3;
  int errs = 0;
  int checks = 0;
  hdr_merge_n #(.NUM_EXP(2), .PIX_WIDTH(8), .USER_WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_i(data_i), .user_i(user_i), .out_valid(out_valid), .out_ready(out_ready),
    .data_o(data_o), .user_o(user_o)
  );
  hdr_merge_n #(.NUM_EXP(3), .PIX_WIDTH(8), .USER_WIDTH(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3),
    .data_i(d3), .user_i(us3), .out_valid(ov3), .out_ready(1'b1),
    .data_o(do3), .user_o(uo3)
  );
  function automatic int ref2(int z0, int z1);
    int w0, w1, d, e, q, r;
    w0 = (z0 <= 127) ? z0 : 255 - z0;
    w1 = (z1 <= 127) ? z1 : 255 - z1;
    d  = w0 + w1;
    if (d == 0) return (z0 > z1) ? z0 : z1;
    e = w0 * z0 + w1 * z1;
    q = e / d;
    r = e % d;
`ifdef HDR_MERGE_ROUND_EN
    if (2 * r >= d) q++;
    if (q > 255) q = 255;
`endif
    return q;
  endfunction
  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || data_o !== 8'd0 || user_o !== 2'd0 || ov3 !== 1'b0) begin
      errs++;
      $display("FAIL reset_outputs: got valid=%b data=%0d user=%0d v3=%b want 0/0/0/0", out_valid, data_o, user_o, ov3);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    rst_n = 1'b1;
    idle(2);
  endtask
  task automatic test_latency;
    int n;
    @(negedge clk);
    data_i   = {8'd200, 8'd100};
    user_i   = 2'd2;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 12) begin
      errs++;
      $display("FAIL latency: got %0d cycles want 12", n);
    end
    checks++;
    if (data_o !== 8'd135 || user_o !== 2'd2) begin
      errs++;
      $display("FAIL merge_100_200: got data=%0d user=%0d want 135/2", data_o, user_o);
    end
    idle(16);
  endtask
  task automatic test_zero_weight;
    logic [15:0] zin [3];
    logic [7:0]  ed  [3];
    logic [1:0]  eu  [3];
    int n;
    zin = '{16'hFF00, 16'h0000, 16'h8080};
    ed  = '{8'd255, 8'd0, 8'd128};
    eu  = '{2'd1, 2'd3, 2'd2};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_i   = zin[i];
      user_i   = eu[i];
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || data_o !== ed[i] || user_o !== eu[i]) begin
        errs++;
        $display("FAIL zero_weight[%0d]: got valid=%b data=%0d user=%0d want 1/%0d/%0d", i, out_valid, data_o, user_o, ed[i], eu[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL zero_weight_tail: got valid=%b want 0", out_valid);
    end
    idle(16);
  endtask
  task automatic test_three_exp;
    int n;
    logic [7:0] want;
`ifdef HDR_MERGE_ROUND_EN
    want = 8'd110;
`else
    want = 8'd109;
`endif
    @(negedge clk);
    d3  = {8'd250, 8'd128, 8'd50};
    us3 = 2'd1;
    iv3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv3 = 1'b0;
    n = 1;
    while (!ov3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 12) begin
      errs++;
      $display("FAIL latency3: got %0d cycles want 12", n);
    end
    checks++;
    if (do3 !== want || uo3 !== 2'd1) begin
      errs++;
      $display("FAIL merge3: got data=%0d user=%0d want %0d/1", do3, uo3, want);
    end
    idle(16);
  endtask
  task automatic test_stall;
    int n;
    @(negedge clk);
    data_i   = {8'd200, 8'd100};
    user_i   = 2'd1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    data_i    = {8'd128, 8'd128};
    user_i    = 2'd3;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || data_o !== 8'd135 || user_o !== 2'd1 || in_ready !== 1'b0) begin
        errs++;
        $display("FAIL stall[%0d]: got valid=%b data=%0d user=%0d in_ready=%b want 1/135/1/0", i, out_valid, data_o, user_o, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL stall_retire: got valid=%b want 0", out_valid);
    end
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 12 || data_o !== 8'd128 || user_o !== 2'd3) begin
      errs++;
      $display("FAIL stall_next: got lat=%0d data=%0d user=%0d want 12/128/3", n, data_o, user_o);
    end
    idle(16);
  endtask
  task automatic test_bubbles;
    logic pat [4];
    logic ov  [17];
    logic want;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    data_i = {8'd200, 8'd100};
    user_i = 2'd0;
    for (int t = 0; t < 18; t++) begin
      @(negedge clk);
      if (t > 0) ov[t-1] = out_valid;
      in_valid = (t < 4) ? pat[t] : 1'b0;
    end
    for (int j = 9; j < 17; j++) begin
      want = (j >= 11 && j <= 14) ? pat[j-11] : 1'b0;
      checks++;
      if (ov[j] !== want) begin
        errs++;
        $display("FAIL bubble[%0d]: got valid=%b want %b", j, ov[j], want);
      end
    end
    idle(16);
  endtask
  task automatic test_stream_random;
    logic [9:0] q [$];
    logic [9:0] e;
    logic [7:0] z0, z1, hd;
    logic [1:0] uu, hu;
    logic held, pend;
    int acc, ret, cyc;
    q.delete();
    acc = 0; ret = 0; cyc = 0;
    held = 1'b0; pend = 1'b0;
    z0 = '0; z1 = '0; uu = '0; hd = '0; hu = '0;
    while (ret < 64 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || data_o !== hd || user_o !== hu) begin
          errs++;
          $display("FAIL stream_hold: got valid=%b data=%0d user=%0d want 1/%0d/%0d", out_valid, data_o, user_o, hd, hu);
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      if (!pend && acc < 64 && $urandom_range(0, 3) != 0) begin
        z0 = 8'($urandom);
        z1 = 8'($urandom);
        uu = 2'($urandom);
        pend = 1'b1;
      end
      in_valid = pend;
      data_i   = {z1, z0};
      user_i   = uu;
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL stream_extra: got data=%0d user=%0d want no beat", data_o, user_o);
        end else begin
          e = q.pop_front();
          if ({user_o, data_o} !== e) begin
            errs++;
            $display("FAIL stream_beat[%0d]: got data=%0d user=%0d want %0d/%0d", ret, data_o, user_o, e[7:0], e[9:8]);
          end
        end
        ret++;
      end
      if (in_valid && in_ready) begin
        q.push_back({uu, 8'(ref2(int'(z0), int'(z1)))});
        acc++;
        pend = 1'b0;
      end
      held = out_valid && !out_ready;
      hd = data_o;
      hu = user_o;
    end
    idle(16);
    checks++;
    if (ret != 64 || acc != 64 || q.size() != 0 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL stream_count: got acc=%0d ret=%0d left=%0d want 64/64/0", acc, ret, q.size());
    end
  endtask
  task automatic test_reset_mid;
    int n, bad;
    out_ready = 1'b1;
    @(negedge clk);
    data_i   = {8'd0, 8'd255};
    user_i   = 2'd1;
    in_valid = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || data_o !== 8'd255) begin
      errs++;
      $display("FAIL pre_reset: got valid=%b data=%0d want 1/255", out_valid, data_o);
    end
    rst_n  = 1'b0;
    data_i = {8'd128, 8'd128};
    user_i = 2'd2;
    #1;
    checks++;
    if (out_valid !== 1'b0 || data_o !== 8'd0 || user_o !== 2'd0) begin
      errs++;
      $display("FAIL mid_reset: got valid=%b data=%0d user=%0d want 0/0/0", out_valid, data_o, user_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 12 || data_o !== 8'd128 || user_o !== 2'd2) begin
      errs++;
      $display("FAIL post_reset_first: got lat=%0d data=%0d user=%0d want 12/128/2", n, data_o, user_o);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || data_o !== 8'd128) bad++;
    end
    checks++;
    if (bad != 0) begin
      errs++;
      $display("FAIL post_reset_stream: got %0d stale or missing beats want 0", bad);
    end
    idle(16);
  endtask
  initial begin
    test_reset;
    test_latency;
    test_zero_weight;
    test_three_exp;
    test_stall;
    test_bubbles;
    test_stream_random;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
